// File: rtl/alu_shift_seq_32bit_pkg.sv
// Shared definitions for the multi-cycle shift unit: widths, op codes and FSM state codes.
package alu_shift_seq_32bit_pkg;

  localparam int N       = 32;
  localparam int SHAMT_W = 5;

  // Op code encoding as presented on the op port.
  typedef enum logic [1:0] {
    ALU_OP_SLL = 2'b00,
    ALU_OP_SRL = 2'b01,
    ALU_OP_SRA = 2'b10,
    ALU_OP_ILL = 2'b11
  } op_e;

  // FSM state encoding; code 2'b11 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_FIN   = 2'b10
  } state_e;

endpackage : alu_shift_seq_32bit_pkg

// File: rtl/alu_shift_seq_32bit_if.sv
// Request/response bundle of the shift unit: start/op/A/shamt in, busy/done/err/Z out.
interface alu_shift_seq_32bit_if;
  import alu_shift_seq_32bit_pkg::*;

  logic               start;
  logic [1:0]         op;
  logic [N-1:0]       A;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic               err;
  logic [N-1:0]       Z;

  // Requester side: issues operations and observes the result.
  modport master (
    output start, op, A, shamt,
    input  busy, done, err, Z
  );

  // Shift unit side.
  modport slave (
    input  start, op, A, shamt,
    output busy, done, err, Z
  );

endinterface : alu_shift_seq_32bit_if

// File: rtl/alu_shift_seq_32bit_step.sv
// Combinational single step of the shifter: shifts work by 'step' bits in the
// direction selected by op_r, filling SRA with the registered sign bit.
module alu_shift_step
  import alu_shift_seq_32bit_pkg::*;
(
  input  logic [N-1:0]       work,
  input  op_e                op_r,
  input  logic               sign_r,
  input  logic [SHAMT_W-1:0] step,
  output logic [N-1:0]       next_work
);

  logic [2*N-1:0] sra_ext;

  // Select the shifted word for the captured op; illegal op leaves work untouched.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    next_work = work;
    sra_ext   = {{N{sign_r}}, work} >> step;
    case (op_r)
      ALU_OP_SLL: next_work = work << step;
      ALU_OP_SRL: next_work = work >> step;
      ALU_OP_SRA: next_work = sra_ext[N-1:0];
      default:    next_work = work;
    endcase
  end

endmodule : alu_shift_step

// File: rtl/alu_shift_seq_32bit.sv
// Multi-cycle SLL/SRL/SRA unit with a start/busy/done handshake.
// Build option: ALU_SHIFT_FAST_EN steps 4 bits per cycle while the remaining
// count is at least 4; otherwise (default) the unit shifts one bit per cycle.
module alu_shift_seq_32bit
  import alu_shift_seq_32bit_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_shift_seq_32bit_if.slave bus
);

  state_e             state_q, state_d;
  logic [N-1:0]       work_q;
  logic [SHAMT_W-1:0] cnt_q;
  op_e                op_q;
  logic               sign_q;
  logic [N-1:0]       z_q;

  logic               accept;
  logic [SHAMT_W-1:0] step_amt;
  logic [N-1:0]       next_work;

  assign accept = (state_q == S_IDLE) && bus.start;

  // Per-cycle shift distance.
  always_comb begin
`ifdef ALU_SHIFT_FAST_EN
    step_amt = (cnt_q >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    step_amt = SHAMT_W'(1);
`endif
  end

  alu_shift_step u_step (
    .work      (work_q),
    .op_r      (op_q),
    .sign_r    (sign_q),
    .step      (step_amt),
    .next_work (next_work)
  );

  // Next-state logic and handshake outputs, all decoded from the state register.
  always_comb begin
    state_d  = S_IDLE;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.shamt == '0 || op_e'(bus.op) == ALU_OP_ILL) state_d = S_FIN;
          else                                                  state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        state_d  = (cnt_q == step_amt) ? S_FIN : S_SHIFT;
      end
      S_FIN: begin
        bus.done = 1'b1;
        bus.err  = (op_q == ALU_OP_ILL);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and shifting; working registers are reset too so a
  // discarded operation leaves no stale operand behind.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these few datapath registers are reset alongside the FSM; the unit holds no memory array.
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_OP_SLL;
      sign_q <= 1'b0;
    end else if (accept) begin
      work_q <= bus.A;
      cnt_q  <= bus.shamt;
      op_q   <= op_e'(bus.op);
      sign_q <= bus.A[N-1];
    end else if (state_q == S_SHIFT) begin
      work_q <= next_work;
      cnt_q  <= cnt_q - step_amt;
    end
  end

  // Result register: loaded on the edge that enters FIN so Z is valid with done,
  // and held through every SHIFT cycle of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else if (accept && state_d == S_FIN) begin
      z_q <= bus.A;
    end else if (state_q == S_SHIFT && state_d == S_FIN) begin
      z_q <= next_work;
    end
  end

  assign bus.Z = z_q;

endmodule : alu_shift_seq_32bit

// File: tb/tb_alu_shift_seq_32bit.sv
// Self-checking bench for alu_shift_seq_32bit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_shift_seq_32bit;

  logic clk;
  logic rst_n;

  alu_shift_seq_32bit_if bus ();

  alu_shift_seq_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] prev_z = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference result straight from the shift definitions.
  function automatic logic [31:0] ref_z(input logic [1:0] op_v, input logic [31:0] a_v,
                                        input logic [4:0] s_v);
    case (op_v)
      2'b00:   return a_v << s_v;
      2'b01:   return a_v >> s_v;
      2'b10:   return $unsigned($signed(a_v) >>> s_v);
      default: return a_v;
    endcase
  endfunction

  // Reference latency in cycles from the accept edge to the done cycle.
  function automatic int ref_lat(input logic [1:0] op_v, input logic [4:0] s_v);
    int s;
    s = int'(s_v);
    if (op_v == 2'b11 || s == 0) return 1;
`ifdef ALU_SHIFT_FAST_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Issue one operation, optionally poke an ignored start mid-flight, and
  // check latency, result, err, Z stability and the one-cycle done pulse.
  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [4:0] s_v, input bit inject);
    logic [31:0] exp_z;
    int          exp_lat;
    int          lat;
    exp_z   = ref_z(op_v, a_v, s_v);
    exp_lat = ref_lat(op_v, s_v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.A     = a_v;
    bus.shamt = s_v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.shamt = 5'($urandom);
    lat = 1;
    while (!bus.done && lat < 64) begin
      if (bus.busy) check({tag, " z_hold"}, bus.Z, prev_z);
      if (inject && lat == 2 && exp_lat > 3) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.A     = $urandom;
        bus.shamt = 5'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " Z"}, bus.Z, exp_z);
    check({tag, " err"}, 32'(bus.err), 32'(op_v == 2'b11));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 32'(bus.done), 32'h0);
    check({tag, " Z_held"}, bus.Z, exp_z);
    prev_z = exp_z;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = 32'h0;
    bus.shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    check("reset err",  32'(bus.err),  32'h0);
    check("reset Z",    bus.Z,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("sll31",  2'b00, 32'h0000_0001, 5'd31, 1'b0);
    check("sll31 value", bus.Z, 32'h8000_0000);
    run_op("sra4",   2'b10, 32'hF000_0000, 5'd4, 1'b0);
    check("sra4 value", bus.Z, 32'hFF00_0000);
    run_op("srl4",   2'b01, 32'hF000_0000, 5'd4, 1'b0);
    check("srl4 value", bus.Z, 32'h0F00_0000);
    run_op("sra0",   2'b10, 32'h1234_5678, 5'd0, 1'b0);
    run_op("ill",    2'b11, 32'hDEAD_BEEF, 5'd9, 1'b0);
    run_op("sra31",  2'b10, 32'h8000_0000, 5'd31, 1'b0);
    run_op("ignore", 2'b00, 32'h0000_00FF, 5'd12, 1'b1);

    // Reset in flight: start SLL by 8, poke start at +3, drop rst_n at +5.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.A     = 32'h0000_0F0F;
    bus.shamt = 5'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort busy_mid", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'h0);
    check("abort Z",    bus.Z,         32'h0);
    check("abort done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abort no_done", 32'(bus.done), 32'h0);
    end
    prev_z = 32'h0;
    run_op("restart", 2'b00, 32'h0000_0F0F, 5'd8, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op_v;
      logic [31:0] a_v;
      logic [4:0]  s_v;
      op_v = 2'($urandom_range(0, 3));
      a_v  = $urandom;
      s_v  = 5'($urandom);
      run_op("rand", op_v, a_v, s_v, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_shift_seq_32bit
